// File: rtl/icache_direct.sv
// Direct-mapped, read-only, one-word-per-line instruction cache with zero-cycle hits
// and single-word fills from the memory arbiter, plus hit/miss performance counters.
module icache_direct #(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state_reg, state_next;
  logic [29:0]       missaddr_reg, missaddr_next;
  logic [31:0]       hit_count_reg, hit_count_next;
  logic [31:0]       miss_count_reg, miss_count_next;
  logic [SETS-1:0]   valid_reg;
  logic [SETS-1:0]   valid_set;
  logic [TAG_W-1:0]  tag_arr [SETS];
  logic [31:0]       data_arr [SETS];

  logic [IDX_W-1:0]  idx, miss_idx;
  logic [TAG_W-1:0]  tag, miss_tag;
  logic              hit, fill_en;
  logic              unused_byte_offset;

  assign idx      = imemaddr[IDX_W+1:2];
  assign tag      = imemaddr[31:IDX_W+2];
  assign miss_idx = missaddr_reg[IDX_W-1:0];
  assign miss_tag = missaddr_reg[29:IDX_W];
  assign unused_byte_offset = ^imemaddr[1:0];

  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;

  always_comb begin
    state_next      = state_reg;
    missaddr_next   = missaddr_reg;
    hit_count_next  = hit_count_reg;
    miss_count_next = miss_count_reg;
    hit             = 1'b0;
    fill_en         = 1'b0;
    ihit            = 1'b0;
    imemload        = 32'd0;
    iREN            = 1'b0;
    iaddr           = 32'd0;
    case (state_reg)
      IDLE: begin
        hit  = imemREN & valid_reg[idx] & (tag_arr[idx] == tag);
        ihit = hit;
        if (hit) begin
          imemload       = data_arr[idx];
          hit_count_next = hit_count_reg + 32'd1;
        end else if (imemREN) begin
          missaddr_next   = imemaddr[31:2];
          miss_count_next = miss_count_reg + 32'd1;
          state_next      = FETCH;
        end
      end
      FETCH: begin
        // Fill always completes for the latched address, even if the PC moved on.
        iREN  = 1'b1;
        iaddr = {missaddr_reg, 2'b00};
        if (!iwait) begin
          fill_en    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < SETS; gi++) begin : g_valid_set
      assign valid_set[gi] = fill_en & (miss_idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg      <= IDLE;
      missaddr_reg   <= 30'd0;
      hit_count_reg  <= 32'd0;
      miss_count_reg <= 32'd0;
      valid_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      missaddr_reg   <= missaddr_next;
      hit_count_reg  <= hit_count_next;
      miss_count_reg <= miss_count_next;
      valid_reg      <= valid_reg | valid_set;
    end
  end

  // Tag/data need no reset; a reset on the fill edge leaves the line invalid anyway.
  always_ff @(posedge CLK) begin
    if (nRST && fill_en) begin
      data_arr[miss_idx] <= iload;
      tag_arr[miss_idx]  <= miss_tag;
    end
  end
endmodule

// File: tb/tb_icache_direct.sv
// Directed, table-driven bench for icache_direct: one vector per clock cycle with
// hand-computed outputs, plus hand-written reset-during-fill sequences.
module tb_icache_direct;
  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks = 0;
  int errors = 0;

  icache_direct dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        wt;
    logic [31:0] ld;
    logic        e_ihit;
    logic [31:0] e_load;
    logic        e_iren;
    logic [31:0] e_iaddr;
    logic [31:0] e_hc;
    logic [31:0] e_mc;
  } vec_t;

  localparam int NVEC = 28;
  vec_t vecs [NVEC];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic e_ihit, input logic [31:0] e_load,
                               input logic e_iren, input logic [31:0] e_iaddr,
                               input logic [31:0] e_hc, input logic [31:0] e_mc);
    check32({tag, ".ihit"},       {31'd0, ihit}, {31'd0, e_ihit});
    check32({tag, ".imemload"},   imemload,      e_load);
    check32({tag, ".iREN"},       {31'd0, iREN}, {31'd0, e_iren});
    check32({tag, ".iaddr"},      iaddr,         e_iaddr);
    check32({tag, ".hit_count"},  hit_count,     e_hc);
    check32({tag, ".miss_count"}, miss_count,    e_mc);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // ren addr iwait iload | ihit imemload iREN iaddr hit_count miss_count
    // Test 1: cold miss on 0x0 with two busy cycles
    vecs[0]  = '{1'b1, 32'h0,   1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,   32'd0, 32'd0};
    vecs[1]  = '{1'b1, 32'h0,   1'b1, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0,   32'd0, 32'd1};
    vecs[2]  = '{1'b1, 32'h0,   1'b1, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0,   32'd0, 32'd1};
    vecs[3]  = '{1'b1, 32'h0,   1'b0, 32'h8C010004, 1'b0, 32'h0,        1'b1, 32'h0,   32'd0, 32'd1};
    vecs[4]  = '{1'b1, 32'h0,   1'b1, 32'h0,        1'b1, 32'h8C010004, 1'b0, 32'h0,   32'd0, 32'd1};
    // Test 2: warm hits
    vecs[5]  = '{1'b1, 32'h0,   1'b1, 32'h0,        1'b1, 32'h8C010004, 1'b0, 32'h0,   32'd1, 32'd1};
    vecs[6]  = '{1'b1, 32'h0,   1'b1, 32'h0,        1'b1, 32'h8C010004, 1'b0, 32'h0,   32'd2, 32'd1};
    vecs[7]  = '{1'b1, 32'h0,   1'b1, 32'h0,        1'b1, 32'h8C010004, 1'b0, 32'h0,   32'd3, 32'd1};
    // Test 3: conflict eviction at index 0
    vecs[8]  = '{1'b1, 32'h40,  1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,   32'd4, 32'd1};
    vecs[9]  = '{1'b1, 32'h40,  1'b0, 32'h11111111, 1'b0, 32'h0,        1'b1, 32'h40,  32'd4, 32'd2};
    vecs[10] = '{1'b1, 32'h40,  1'b1, 32'h0,        1'b1, 32'h11111111, 1'b0, 32'h0,   32'd4, 32'd2};
    vecs[11] = '{1'b1, 32'h0,   1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,   32'd5, 32'd2};
    vecs[12] = '{1'b1, 32'h0,   1'b0, 32'h8C010004, 1'b0, 32'h0,        1'b1, 32'h0,   32'd5, 32'd3};
    vecs[13] = '{1'b1, 32'h0,   1'b1, 32'h0,        1'b1, 32'h8C010004, 1'b0, 32'h0,   32'd5, 32'd3};
    // Test 4: redirect while the fill for 0x104 is outstanding
    vecs[14] = '{1'b1, 32'h104, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,   32'd6, 32'd3};
    vecs[15] = '{1'b1, 32'h208, 1'b1, 32'h0,        1'b0, 32'h0,        1'b1, 32'h104, 32'd6, 32'd4};
    vecs[16] = '{1'b1, 32'h208, 1'b1, 32'h0,        1'b0, 32'h0,        1'b1, 32'h104, 32'd6, 32'd4};
    vecs[17] = '{1'b1, 32'h208, 1'b0, 32'h22222222, 1'b0, 32'h0,        1'b1, 32'h104, 32'd6, 32'd4};
    vecs[18] = '{1'b1, 32'h208, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,   32'd6, 32'd4};
    vecs[19] = '{1'b1, 32'h208, 1'b0, 32'h33333333, 1'b0, 32'h0,        1'b1, 32'h208, 32'd6, 32'd5};
    vecs[20] = '{1'b1, 32'h104, 1'b1, 32'h0,        1'b1, 32'h22222222, 1'b0, 32'h0,   32'd6, 32'd5};
    vecs[21] = '{1'b1, 32'h208, 1'b1, 32'h0,        1'b1, 32'h33333333, 1'b0, 32'h0,   32'd7, 32'd5};
    // Test 6: idle requests leave everything untouched
    vecs[22] = '{1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 32'h0,   32'd8, 32'd5};
    vecs[23] = '{1'b0, 32'h104,      1'b1, 32'h0,   1'b0, 32'h0,        1'b0, 32'h0,   32'd8, 32'd5};
    vecs[24] = '{1'b0, 32'hDEADBEEF, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 32'h0,   32'd8, 32'd5};
    vecs[25] = '{1'b0, 32'h208,      1'b1, 32'h0,   1'b0, 32'h0,        1'b0, 32'h0,   32'd8, 32'd5};
    // Byte offset bits are ignored on lookup
    vecs[26] = '{1'b1, 32'h106, 1'b1, 32'h0,        1'b1, 32'h22222222, 1'b0, 32'h0,   32'd8, 32'd5};
    vecs[27] = '{1'b0, 32'h106, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,   32'd9, 32'd5};

    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    iwait    = 1'b1;
    iload    = 32'h0;
    next_cycle();
    nRST = 1'b1;
    @(negedge CLK);
    check_outputs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'd0, 32'd0);
    next_cycle();

    for (int i = 0; i < NVEC; i++) begin
      imemREN  = vecs[i].ren;
      imemaddr = vecs[i].addr;
      iwait    = vecs[i].wt;
      iload    = vecs[i].ld;
      @(negedge CLK);
      $display("vec %0d: ren=%0b addr=0x%08h ihit=%0b load=0x%08h iREN=%0b iaddr=0x%08h hc=%0d mc=%0d",
               i, imemREN, imemaddr, ihit, imemload, iREN, iaddr, hit_count, miss_count);
      check_outputs($sformatf("vec%0d", i), vecs[i].e_ihit, vecs[i].e_load, vecs[i].e_iren,
                    vecs[i].e_iaddr, vecs[i].e_hc, vecs[i].e_mc);
      next_cycle();
    end

    // Test 5: reset while a fill for 0x10 is pending (iwait=1)
    imemREN = 1'b1; imemaddr = 32'h10; iwait = 1'b1;
    @(negedge CLK);
    check_outputs("rst5.detect", 1'b0, 32'h0, 1'b0, 32'h0, 32'd9, 32'd5);
    next_cycle();
    @(negedge CLK);
    check_outputs("rst5.fetch", 1'b0, 32'h0, 1'b1, 32'h10, 32'd9, 32'd6);
    $display("seq reset-mid-fill: asserting nRST with iREN=%0b iaddr=0x%08h", iREN, iaddr);
    nRST = 1'b0;
    next_cycle();
    nRST = 1'b1; imemREN = 1'b0;
    @(negedge CLK);
    check_outputs("rst5.after", 1'b0, 32'h0, 1'b0, 32'h0, 32'd0, 32'd0);
    next_cycle();
    imemREN = 1'b1; imemaddr = 32'h0;
    @(negedge CLK);
    check_outputs("rst5.refetch", 1'b0, 32'h0, 1'b0, 32'h0, 32'd0, 32'd0);
    next_cycle();
    iwait = 1'b0; iload = 32'hCAFEF00D;
    @(negedge CLK);
    check_outputs("rst5.refill", 1'b0, 32'h0, 1'b1, 32'h0, 32'd0, 32'd1);
    next_cycle();
    iwait = 1'b1;
    @(negedge CLK);
    check_outputs("rst5.hit", 1'b1, 32'hCAFEF00D, 1'b0, 32'h0, 32'd0, 32'd1);
    $display("seq reset-mid-fill: refetch hit=%0b load=0x%08h", ihit, imemload);
    next_cycle();

    // Reset on the same edge a fill completes: the line must stay invalid
    imemaddr = 32'h20;
    @(negedge CLK);
    check_outputs("rstfill.detect", 1'b0, 32'h0, 1'b0, 32'h0, 32'd1, 32'd1);
    next_cycle();
    iwait = 1'b0; iload = 32'h55AA55AA; nRST = 1'b0;
    @(negedge CLK);
    check_outputs("rstfill.fetch", 1'b0, 32'h0, 1'b1, 32'h20, 32'd1, 32'd2);
    next_cycle();
    nRST = 1'b1; iwait = 1'b1;
    @(negedge CLK);
    check_outputs("rstfill.after", 1'b0, 32'h0, 1'b0, 32'h0, 32'd0, 32'd0);
    $display("seq reset-on-fill: after reset ihit=%0b miss_count=%0d", ihit, miss_count);
    next_cycle();
    @(negedge CLK);
    check_outputs("rstfill.miss", 1'b0, 32'h0, 1'b1, 32'h20, 32'd0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the pipelined datapath's fetch port and the memory arbiter.
- Datapath side: consumes imemREN/imemaddr and returns ihit/imemload.
- Memory side: issues single-word fills on misses.
- Keeps hit/miss performance counters for bench and debug use.

Parameters:
SETS, 16, number of one-word cache lines; power of two, at least 2.
IDX_W, log2(SETS) = 4, index width; tag width TAG_W = 30 - IDX_W = 26.

Ports:
CLK  input  1  system clock, rising-edge
nRST  input  1  synchronous active-low reset
imemREN  input  1  datapath fetch request
imemaddr  input  32  datapath fetch byte address
ihit  output  1  requested word valid this cycle
imemload  output  32  instruction word; 0 when ihit=0
iREN  output  1  memory fill request
iaddr  output  32  memory fill word address
iwait  input  1  memory busy; fill data valid when iwait=0 and iREN=1
iload  input  32  memory fill data
hit_count  output  32  number of hit cycles
miss_count  output  32  number of misses (IDLE->FETCH transitions)

Behaviour:
- Reset: one clock, reset is synchronous and active-low (nRST sampled on rising CLK).
  - At a reset edge: all valid bits cleared, state=IDLE, latched address=0, both counters=0.
  - Tag/data arrays need not be cleared.
  - Reset overrides every other event, including a fill completing on the same edge.
  - After a reset edge: ihit=0, imemload=0, iREN=0, iaddr=0.
- Address split: [1:0] ignored; idx=[IDX_W+1:2]; tag=[31:IDX_W+2].
- State IDLE:
  - hit = imemREN & valid[idx] & (tagarr[idx]==tag). Combinational.
  - ihit=hit and imemload=data[idx] in the same cycle; zero-cycle hit latency.
  - If imemREN & ~hit: latch {imemaddr[31:2],2'b00} into missaddr, increment miss_count, go to FETCH.
  - Each IDLE cycle with hit=1 increments hit_count.
  - iREN=0, iaddr=0.
- State FETCH:
  - Outputs: iREN=1, iaddr=missaddr, ihit=0, imemload=0.
  - When iwait=0: on that edge, write data[missidx]=iload, tagarr[missidx]=misstag, valid[missidx]=1, then go to IDLE.
  - When iwait=1: stay in FETCH.
- Miss latency: 1 detect cycle, then FETCH cycles until iwait=0, then the IDLE hit cycle. The filled word is not forwarded.
- imemaddr changes or imemREN drops during FETCH (PC redirect, flush, halt):
  - The fill completes for the latched missaddr; it is not aborted.
  - On return to IDLE, the current imemaddr is re-evaluated; it may miss again.
- A fill replaces any prior line at that index (conflict eviction). No write port and no dirty state.
- Counters wrap modulo 2^32.
- imemREN=0 in IDLE: no state change, no counter change.
- Counters are not incremented while nRST is low.

Test Plan:
1. Cold miss:
   - Stimulus: reset; imemREN=1, imemaddr=0x00000000; memory holds iwait=1 for 2 cycles, then iwait=0 with iload=0x8C010004.
   - Required: cycle 0 ihit=0. FETCH shows iREN=1, iaddr=0x00000000. The cycle after the fill shows ihit=1, imemload=0x8C010004, iREN=0. miss_count=1.
2. Warm hit:
   - Stimulus: following test 1, hold imemaddr=0x00000000 for 3 cycles.
   - Required: ihit=1 each cycle, iREN never asserted, hit_count increases by 3.
3. Conflict eviction:
   - Stimulus: fetch 0x00000040 (idx 0, new tag), then 0x00000000.
   - Required: both miss; iaddr=0x00000040, then iaddr=0x00000000; miss_count increases by 2.
4. Redirect mid-fill:
   - Stimulus: miss on 0x00000104 (idx 1); while iwait=1, change imemaddr to 0x00000208.
   - Required: iaddr stays 0x00000104; idx 1 becomes valid; back in IDLE, 0x00000208 misses and iaddr=0x00000208.
5. Reset mid-fill:
   - Stimulus: with 0x00000000 cached, start a miss on 0x00000010; pull nRST low for one edge while iwait=1.
   - Required: next cycle iREN=0, counters=0; a later fetch of 0x00000000 misses (valid cleared).
6. Idle request:
   - Stimulus: imemREN=0 with any imemaddr for 4 cycles.
   - Required: ihit=0, imemload=0, iREN=0, counters unchanged.
